li_mem_op_seq: RTL
==================

Name: li_mem_op_seq

Overview:
- Initiator/controller that drives the control interface of a bank of logic-in-memory DFFs.
- Accepts opcode+operand commands on a valid/ready handshake.
- Converts each command into one or two cycles of do_force/do_invert/do_nand/do_nxor/in control words, so the DFF computes f(stored, operand).
- Parks the bank in HOLD when idle. The DFF's own output is not an input here.

Parameters:
- WIDTH, 8, operand and DFF data width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_op  input  4  opcode (encodings in Behaviour).
- cmd_data  input  WIDTH  operand.
- do_force  output  1  to DFF bank.
- do_invert  output  1  to DFF bank.
- do_nand  output  1  to DFF bank.
- do_nxor  output  1  to DFF bank.
- dff_in  output  WIDTH  to DFF bank in.
- op_done  output  1  final control word of a command is being driven this cycle.
- busy  output  1  a command is in progress.
- err  output  1  one-cycle pulse: reserved opcode accepted.

Behaviour:
- Control words are written {force,invert,nand,nxor,in}. The DFF bank samples a word at the rising edge that ends the cycle in which the word is driven.
- All outputs are registered except cmd_ready.
- Reset values: HOLD word {0,1,0,0,0}, op_done=0, busy=0, err=0, state=IDLE.
- States: IDLE, STEP1, STEP2.
- Accept: cmd_valid & cmd_ready at edge N. The first word is driven in cycle N+1.
- Single-step opcodes go IDLE->STEP1. In STEP1: op_done=1, busy=1.
- Two-step opcodes go IDLE->STEP1->STEP2. op_done=1 only in STEP2.
- cmd_ready=1 in IDLE, and in the final step of a command. This allows back-to-back commands with no HOLD gap.
  - Accept in the final step: next state is STEP1 of the new command.
  - Otherwise the next state is IDLE.
- cmd_ready=0 in STEP1 of a two-step command.
- In IDLE the HOLD word is driven: nor(cur,0) inverted = cur.
- Opcode encodings (force,invert,nand,nxor,in):
  - 0 HOLD: 0,1,0,0,0
  - 1 LOAD: 1,0,0,0,data
  - 2 LOADN: 1,1,0,0,data
  - 3 AND: 0,1,1,0,data
  - 4 NAND: 0,0,1,0,data
  - 5 OR: 0,1,0,0,data
  - 6 NOR: 0,0,0,0,data
  - 7 XOR: 0,1,0,1,data
  - 8 XNOR: 0,0,0,1,data
  - 9 CLEAR: 1,0,0,0,0
  - 10 SET: 1,1,0,0,0
  - 11 NOT: 0,0,0,1,0
  - 12 ANDN (cur & ~data), two steps: NOT word, then NOR word with data.
  - 13 ORN (cur | ~data), two steps: NOT word, then NAND word with data.
  - 14,15 reserved: executed as single-step HOLD; err=1 during that STEP1 cycle.
- do_nand and do_nxor are never both 1.
- cmd_data is latched at acceptance and held for both steps. Input changes after acceptance have no effect.
- rst mid-command: next cycle is IDLE with the HOLD word.
  - An abandoned ANDN/ORN leaves the bank holding ~cur.
  - No op_done pulse is issued for the abandoned command.
- cmd_valid while cmd_ready=0 is ignored. The requester must hold it.

Optional Feature:
- Macro: LI_MEM_SEQ_SHADOW_EN.
- Defined:
  - Adds outputs shadow_val [WIDTH] and shadow_valid [1].
  - shadow_val mirrors the expected DFF content and is updated at the same edge the bank samples each non-idle word, using the same function.
  - shadow_valid resets to 0. It is set at the first completed LOAD, LOADN, CLEAR or SET, because the bank itself has no reset.
  - shadow_val resets to 0.
- Undefined: no shadow ports or logic. Behaviour is otherwise identical.

Test Plan (WIDTH=8, golden DFF model attached to the control outputs):
- After rst, CLEAR then LOAD 0xA5 back-to-back -> words on consecutive cycles; op_done=1 both cycles; bank=0xA5; cmd_ready never drops.
- Bank=0xA5, then XOR 0xFF, AND 0x0F, OR 0x30 -> bank 0x5A, then 0x0A, then 0x3A.
- Bank=0xF0, ANDN 0x30 -> cmd_ready=0 for one cycle; STEP1 word {0,0,0,1,0}; op_done only in STEP2; bank=0xC0.
- Bank=0xF0, ORN 0x0F; cmd_data changes to 0x00 after accept -> bank=0xF0 (latched operand used).
- Opcode 14 with bank=0x3C -> err single-cycle pulse; bank stays 0x3C; op_done=1.
- Assert rst during STEP1 of ANDN with bank=0x55 -> HOLD word next cycle; bank=0xAA; busy=0; no op_done. With shadow enabled: shadow_valid=0 after rst, and 1 with shadow_val matching the model after SET.

Source files
------------

// File: rtl/li_mem_op_seq_if.sv
// li_mem_op_seq_if: command handshake and DFF-bank control bundle (shadow ports when LI_MEM_SEQ_SHADOW_EN)
interface li_mem_op_seq_if #(parameter int WIDTH = 8);
  logic cmd_valid;
  logic cmd_ready;
  logic [3:0] cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic do_force;
  logic do_invert;
  logic do_nand;
  logic do_nxor;
  logic [WIDTH-1:0] dff_in;
  logic op_done;
  logic busy;
  logic err;
`ifdef LI_MEM_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_val;
  logic shadow_valid;
  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input cmd_ready, do_force, do_invert, do_nand, do_nxor, dff_in, op_done, busy, err, shadow_val, shadow_valid
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_data,
    output cmd_ready, do_force, do_invert, do_nand, do_nxor, dff_in, op_done, busy, err, shadow_val, shadow_valid
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input cmd_ready, do_force, do_invert, do_nand, do_nxor, dff_in, op_done, busy, err
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_data,
    output cmd_ready, do_force, do_invert, do_nand, do_nxor, dff_in, op_done, busy, err
  );
`endif
endinterface

// File: rtl/li_mem_op_seq.sv
// li_mem_op_seq: turns opcode+operand commands into logic-in-memory DFF control words (clk, rst, bus: cmd handshake in, do_*/dff_in/op_done/busy/err out; shadow_val/shadow_valid when LI_MEM_SEQ_SHADOW_EN)
module li_mem_op_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  li_mem_op_seq_if.slave bus
);
  localparam int W = WIDTH + 4;
  localparam logic [W-1:0] HOLD = {4'b0100, {WIDTH{1'b0}}};
  typedef enum logic [1:0] {IDLE, STEP1, STEP2} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [W-1:0] word_q, word_d;
  logic op_done_q, op_done_d;
  logic busy_q, busy_d;
  logic err_q, err_d;
  logic two_step, new_two, ready, acc;
  function automatic logic [W-1:0] word_f(input logic [3:0] op, input logic [WIDTH-1:0] d);
    case (op)
      4'd1: return {4'b1000, d};
      4'd2: return {4'b1100, d};
      4'd3: return {4'b0110, d};
      4'd4: return {4'b0010, d};
      4'd5: return {4'b0100, d};
      4'd6: return {4'b0000, d};
      4'd7: return {4'b0101, d};
      4'd8: return {4'b0001, d};
      4'd9: return {4'b1000, {WIDTH{1'b0}}};
      4'd10: return {4'b1100, {WIDTH{1'b0}}};
      4'd11, 4'd12, 4'd13: return {4'b0001, {WIDTH{1'b0}}};
      default: return HOLD;
    endcase
  endfunction
  assign two_step = op_q == 4'd12 || op_q == 4'd13;
  assign new_two = bus.cmd_op == 4'd12 || bus.cmd_op == 4'd13;
  assign ready = state_q != STEP1 || !two_step;
  assign acc = bus.cmd_valid && ready;
  always_comb begin
    state_d = acc ? STEP1 : (state_q == STEP1 && two_step) ? STEP2 : IDLE;
    op_d = acc ? bus.cmd_op : op_q;
    data_d = acc ? bus.cmd_data : data_q;
    word_d = acc ? word_f(bus.cmd_op, bus.cmd_data) :
             state_d == STEP2 ? word_f(op_q == 4'd12 ? 4'd6 : 4'd4, data_q) : HOLD;
    op_done_d = acc ? !new_two : state_d == STEP2;
    busy_d = state_d != IDLE;
    err_d = acc && bus.cmd_op[3:1] == 3'b111;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      data_q <= '0;
      word_q <= HOLD;
      op_done_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      word_q <= word_d;
      op_done_q <= op_done_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  assign bus.cmd_ready = ready;
  assign {bus.do_force, bus.do_invert, bus.do_nand, bus.do_nxor, bus.dff_in} = word_q;
  assign bus.op_done = op_done_q;
  assign bus.busy = busy_q;
  assign bus.err = err_q;
`ifdef LI_MEM_SEQ_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic shadow_valid_q, shadow_valid_d;
  function automatic logic [WIDTH-1:0] dff_f(input logic [WIDTH-1:0] cur, input logic [W-1:0] w);
    logic [WIDTH-1:0] b;
    b = w[W-1] ? w[WIDTH-1:0] : w[W-3] ? ~(cur & w[WIDTH-1:0]) :
        w[W-4] ? ~(cur ^ w[WIDTH-1:0]) : ~(cur | w[WIDTH-1:0]);
    return w[W-2] ? ~b : b;
  endfunction
  always_comb begin
    shadow_d = busy_q ? dff_f(shadow_q, word_q) : shadow_q;
    shadow_valid_d = shadow_valid_q || (op_done_q && (op_q == 4'd1 || op_q == 4'd2 || op_q == 4'd9 || op_q == 4'd10));
  end
  always_ff @(posedge clk)
    if (rst) begin
      shadow_q <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  assign bus.shadow_val = shadow_q;
  assign bus.shadow_valid = shadow_valid_q;
`endif
endmodule
